// File: rtl/rng_multi_axil_if.sv
// ---------------------------------------------------------------------------
// rng_multi_axil_if
// AXI4-Lite slave bus bundle for rng_multi_axil.
//   master modport : drives AW/W/AR valid+payload, BREADY, RREADY
//   slave  modport : drives AWREADY, WREADY, B response, ARREADY, R response
// ---------------------------------------------------------------------------
interface rng_multi_axil_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic                            S_AXI_AWVALID;
    logic                            S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                            S_AXI_WVALID;
    logic                            S_AXI_WREADY;
    logic [1:0]                      S_AXI_BRESP;
    logic                            S_AXI_BVALID;
    logic                            S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic                            S_AXI_ARVALID;
    logic                            S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                      S_AXI_RRESP;
    logic                            S_AXI_RVALID;
    logic                            S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/rng_multi_axil.sv
// ---------------------------------------------------------------------------
// rng_multi_axil
// Bank of NUM_CH 32-bit Galois LFSRs behind an AXI4-Lite slave.
//   0x00 CTRL   : bit0 FREE (free-run), bits[8+NUM_CH-1:8] EN per channel
//   0x04 STATUS : {23'b0, FREERUN_PRESENT, 4'b0, NUM_CH[3:0]}, read-only
//   0x10+4*ch   : DATA[ch]; read returns the value and advances (if enabled),
//                 write re-seeds (byte-merged; an all-zero seed becomes 1)
// Ports:
//   ACLK   : sole clock, rising edge
//   ARESET : synchronous active-high reset
//   s_axi  : rng_multi_axil_if.slave AXI4-Lite bus
// Build option: define RNG_FREERUN_EN to build the CTRL.FREE free-run step.
// ---------------------------------------------------------------------------
module rng_multi_axil #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 6,
    parameter int          NUM_CH             = 4,
    parameter logic [31:0] POLY               = 32'h80200003,
    parameter logic [31:0] SEED_INIT          = 32'h00000001
) (
    input logic             ACLK,
    input logic             ARESET,
    rng_multi_axil_if.slave s_axi
);
    localparam int                DW      = C_S_AXI_DATA_WIDTH;
    localparam int                WW      = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [WW-1:0]     W_CTRL  = WW'(0);
    localparam logic [WW-1:0]     W_STAT  = WW'(1);
    localparam logic [WW-1:0]     W_DATA0 = WW'(4);
    localparam logic [1:0]        OKAY    = 2'b00;
    localparam logic [1:0]        SLVERR  = 2'b10;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? POLY : 32'h0);
    endfunction

    function automatic logic [31:0] strb_merge(input logic [31:0] old,
                                               input logic [31:0] wd,
                                               input logic [3:0]  st);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = st[b] ? wd[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

    // An LFSR stuck at zero never leaves it, so a zero seed is replaced by 1.
    function automatic logic [31:0] seed_fix(input logic [31:0] s);
        return (s == 32'h0) ? 32'h00000001 : s;
    endfunction

    // Control / state registers
    logic              axready_q, axready_d;   // shared AWREADY/WREADY pulse
    logic              bvalid_q,  bvalid_d;
    logic [1:0]        bresp_q,   bresp_d;
    logic              arready_q, arready_d;
    logic              rvalid_q,  rvalid_d;
    logic [1:0]        rresp_q,   rresp_d;
    logic [DW-1:0]     rdata_q,   rdata_d;
    logic [NUM_CH-1:0] en_q,      en_d;
    logic [31:0]       lfsr_q [NUM_CH];
    logic [31:0]       lfsr_d [NUM_CH];

    logic              free_step;

`ifdef RNG_FREERUN_EN
    localparam logic FREERUN_PRESENT = 1'b1;
    logic free_q, free_d;
`else
    localparam logic FREERUN_PRESENT = 1'b0;
`endif

    localparam logic [31:0] STATUS_VAL = {23'b0, FREERUN_PRESENT, 4'b0, 4'(NUM_CH)};

    // Decode
    logic [WW-1:0]     aw_word, ar_word;
    logic              aw_align, ar_align;
    logic              wr_fire, rd_fire;
    logic              wr_ctrl, wr_err;
    logic [NUM_CH-1:0] wr_hit, rd_hit;
    logic [31:0]       ctrl_rd, rd_val;
    logic              rd_err;

    always_comb begin
        aw_word  = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        ar_word  = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
        aw_align = (s_axi.S_AXI_AWADDR[1:0] == 2'b00);
        ar_align = (s_axi.S_AXI_ARADDR[1:0] == 2'b00);

        // Handshake edges: ready was raised last cycle and valids are held.
        wr_fire = axready_q && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID;
        rd_fire = arready_q && s_axi.S_AXI_ARVALID;

        wr_ctrl = aw_align && (aw_word == W_CTRL);
        wr_hit  = '0;
        rd_hit  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit[i] = aw_align && (aw_word == W_DATA0 + WW'(i));
            rd_hit[i] = ar_align && (ar_word == W_DATA0 + WW'(i));
        end
        // STATUS is read-only, so a write to it falls into the error case.
        wr_err = !(wr_ctrl || (|wr_hit));

        ctrl_rd               = '0;
        ctrl_rd[0]            = free_step;
        ctrl_rd[8 +: NUM_CH]  = en_q;

        rd_val = '0;
        rd_err = 1'b1;
        if (ar_align && ar_word == W_CTRL) begin
            rd_val = ctrl_rd;
            rd_err = 1'b0;
        end else if (ar_align && ar_word == W_STAT) begin
            rd_val = STATUS_VAL;
            rd_err = 1'b0;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_hit[i]) begin
                rd_val = lfsr_q[i];
                rd_err = 1'b0;
            end
        end
    end

    // Next state
    always_comb begin
        axready_d = !axready_q && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID && !bvalid_q;
        arready_d = !arready_q && s_axi.S_AXI_ARVALID && !rvalid_q;

        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (wr_fire) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_err ? SLVERR : OKAY;
        end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end

        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (rd_fire) begin
            rvalid_d = 1'b1;
            rresp_d  = rd_err ? SLVERR : OKAY;
            rdata_d  = rd_val;
        end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end

        en_d = en_q;
        if (wr_fire && wr_ctrl && s_axi.S_AXI_WSTRB[1])
            en_d = s_axi.S_AXI_WDATA[8 +: NUM_CH];

        // Seed write wins; read-advance and free-run collapse to one step.
        // en_q is the pre-edge value, so a same-edge CTRL write has no effect here.
        for (int i = 0; i < NUM_CH; i++) begin
            lfsr_d[i] = lfsr_q[i];
            if (wr_fire && wr_hit[i])
                lfsr_d[i] = seed_fix(strb_merge(lfsr_q[i], s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB));
            else if (en_q[i] && ((rd_fire && rd_hit[i]) || free_step))
                lfsr_d[i] = lfsr_step(lfsr_q[i]);
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            axready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            en_q      <= '1;
            for (int i = 0; i < NUM_CH; i++)
                lfsr_q[i] <= SEED_INIT + 32'(i);
        end else begin
            axready_q <= axready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            en_q      <= en_d;
            for (int i = 0; i < NUM_CH; i++)
                lfsr_q[i] <= lfsr_d[i];
        end
    end

`ifdef RNG_FREERUN_EN
    always_comb begin
        free_d = free_q;
        if (wr_fire && wr_ctrl && s_axi.S_AXI_WSTRB[0])
            free_d = s_axi.S_AXI_WDATA[0];
    end

    always_ff @(posedge ACLK) begin
        if (ARESET)
            free_q <= 1'b0;
        else
            free_q <= free_d;
    end

    assign free_step = free_q;
`else
    assign free_step = 1'b0;
`endif

    assign s_axi.S_AXI_AWREADY = axready_q;
    assign s_axi.S_AXI_WREADY  = axready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;

endmodule

// File: doc/rng_multi_axil.md
RNG_MULTI_AXIL -- requirements
Module: rng_multi_axil

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 6, byte address width.
REQ-003 SHALL have parameter NUM_CH, default 4, number of independent LFSR channels (legal range 1..8).
REQ-004 SHALL have parameter POLY, default 32'h80200003, Galois feedback mask shared by all channels.
REQ-005 SHALL have parameter SEED_INIT, default 32'h00000001; channel ch resets to SEED_INIT+ch.
REQ-006 SHALL run on one clock, with a synchronous, active-high reset.
REQ-007 ACLK  in  1  sole clock; all state changes on rising edge.
REQ-008 ARESET  in  1  synchronous active-high reset.
REQ-009 S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
REQ-010 S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
REQ-011 S_AXI_WDATA  in  32, S_AXI_WSTRB  in  4  write data, byte enables.
REQ-012 S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
REQ-013 S_AXI_BRESP  out  2, S_AXI_BVALID  out  1, S_AXI_BREADY  in  1  write response.
REQ-014 S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH, S_AXI_ARVALID  in  1, S_AXI_ARREADY  out  1  read address.
REQ-015 S_AXI_RDATA  out  32, S_AXI_RRESP  out  2, S_AXI_RVALID  out  1, S_AXI_RREADY  in  1  read data.

Function
REQ-016 Register map SHALL be: 0x00 CTRL (RW), 0x04 STATUS (RO), 0x10+4*ch DATA[ch] for ch<NUM_CH; any other offset is unmapped.
REQ-017 CTRL SHALL be: bit0 FREE, bits[8+NUM_CH-1:8] EN[ch]; all other bits read 0 and ignore writes.
REQ-018 STATUS SHALL read {23'b0, FREERUN_PRESENT, 4'b0, NUM_CH[3:0]}.
REQ-019 LFSR step SHALL be: s_next = (s>>1) ^ (s[0] ? POLY : 0).
REQ-020 Write channel SHALL accept AW and W together: AWREADY and WREADY pulse high for exactly one cycle when AWVALID && WVALID && !BVALID; BVALID rises on the following cycle and holds until BREADY.
REQ-021 Read channel SHALL pulse ARREADY for one cycle when ARVALID && !RVALID; RVALID rises on the next cycle with RDATA/RRESP stable until RREADY.
REQ-022 One transaction per direction outstanding; read and write MAY complete in the same cycle.
REQ-023 A DATA[ch] read SHALL return the LFSR value present at the AR handshake edge; the LFSR SHALL advance one step on that edge if EN[ch]=1.
REQ-024 A DATA[ch] write SHALL load the LFSR with WDATA merged by WSTRB; a resulting value of 0 SHALL load 32'h00000001.
REQ-025 CTRL writes SHALL honour WSTRB.
REQ-026 Same-edge priority per channel: seed write > read-advance/free-run step; read-advance and free-run step on the same edge SHALL advance exactly one step.
REQ-027 EN sampled before the edge SHALL govern advance; disabled channels hold value and still return it on read.
REQ-028 Responses SHALL be OKAY (2'b00) for mapped accesses; SLVERR (2'b10) for unmapped offsets and STATUS writes, with RDATA=0 on error reads and no state change.

Reset
REQ-029 On ARESET: AWREADY, WREADY, ARREADY, BVALID, RVALID=0; BRESP, RRESP, RDATA=0; CTRL.FREE=0; EN=all ones; LFSR[ch]=SEED_INIT+ch.
REQ-030 Reset asserted mid-transaction SHALL drop the pending response without completing it.

Configuration
REQ-031 Macro RNG_FREERUN_EN defined: CTRL.FREE=1 SHALL step every enabled channel every ACLK; FREERUN_PRESENT=1.
REQ-032 Macro RNG_FREERUN_EN undefined: FREE SHALL read 0 and ignore writes, no free-run logic built; FREERUN_PRESENT=0.

Verification
REQ-033 After reset, three reads of 0x10 -> 0x00000001, 0x80200003, 0xC0300002; reads of 0x14 -> 0x00000002, then 0x00000001.
REQ-034 Write 0x00000000 to 0x18, read 0x18 -> 0x00000001, OKAY.
REQ-035 Write CTRL=0x00000E00 (EN0=0), read 0x10 twice -> 0x00000001 both times; read 0x14 still advances.
REQ-036 Read 0x30 (NUM_CH=4) -> RRESP=2'b10, RDATA=0; write 0x04 -> BRESP=2'b10, STATUS unchanged (reads 0x00000104 with macro, 0x00000004 without).
REQ-037 With RNG_FREERUN_EN, write CTRL=0x00000F01, wait 2 cycles after BVALID, read 0x10 -> value matches reference model step count; hold RREADY low 5 cycles -> RDATA stable.
REQ-038 Assert ARESET during a pending BVALID -> BVALID=0 next cycle, all LFSRs back to SEED_INIT+ch.
